uart_calc_ctrl: RTL

- Command interpreter between the UART receiver/transmitter and the ALU in the TP2 calculator top.
- Consumes received ASCII bytes of the form `<A><op><B><CR>` (for example "2-1\r").
- Drives operands and opcode to a combinational ALU, latches the result, and sends it back over the UART transmitter as two ASCII hex digits followed by CR.
- Exposes the result on LEDS and its FSM state on STATE for debug.

---
 rtl/uart_calc_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_calc_ctrl.sv
// Calculator command interpreter: parses "<A><op><B><CR>" from the UART, drives the ALU and returns the result as two hex digits + CR.
// Optional CALC_ECHO_EN: echo every accepted byte on TX before parsing it.
module uart_calc_ctrl #(
  parameter int         DATA_W     = 8,
  parameter int         MAX_DIGITS = 3,
  parameter logic [7:0] CR_CHAR    = 8'h0D
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [5:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_res,
  output logic [7:0]        o_leds,
  output logic [7:0]        o_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_A = 3'd0, S_B = 3'd1, S_EXEC = 3'd2, S_TX_HI = 3'd3,
    S_TX_LO = 3'd4, S_TX_CR = 3'd5, S_WAIT = 3'd6, S_ERR = 3'd7
  } state_t;

  state_t            r_state, w_state_n, r_ret, w_ret_n;
  logic [DATA_W-1:0] r_a, w_a_n, r_b, w_b_n, r_res, w_res_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [5:0]        r_op, w_op_n;
  logic [7:0]        r_leds, w_leds_n, r_tx_data, w_tx_data_n;
  logic              r_tx_start, w_tx_start_n;

  logic [7:0] w_byte;
  logic       w_parse_v, w_echo_go, w_ret_clear;
  logic       w_is_digit, w_op_ok;
  logic [5:0] w_opcode;

`ifdef CALC_ECHO_EN
  // r_echo marks a byte that has been echoed and still awaits parsing
  logic       r_echo, w_echo_n;
  logic [7:0] r_rx_byte, w_rx_byte_n;
  assign w_byte      = r_rx_byte;
  assign w_parse_v   = r_echo;
  assign w_echo_go   = !r_echo && i_rx_done;
  assign w_ret_clear = !r_echo;
`else
  assign w_byte      = i_rx_data;
  assign w_parse_v   = i_rx_done;
  assign w_echo_go   = 1'b0;
  assign w_ret_clear = 1'b1;
`endif

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [DATA_W-1:0] f_acc(input logic [DATA_W-1:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + DATA_W'(d);
  endfunction

  assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);

  always_comb begin
    w_op_ok  = 1'b1;
    w_opcode = 6'b100000;
    case (w_byte)
      8'h2B:   w_opcode = 6'b100000;
      8'h2D:   w_opcode = 6'b100010;
      8'h26:   w_opcode = 6'b100100;
      8'h7C:   w_opcode = 6'b100101;
      8'h5E:   w_opcode = 6'b100110;
      8'h7E:   w_opcode = 6'b100111;
      default: w_op_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n    = r_state;
    w_ret_n      = r_ret;
    w_a_n        = r_a;
    w_b_n        = r_b;
    w_res_n      = r_res;
    w_cnt_n      = r_cnt;
    w_op_n       = r_op;
    w_leds_n     = r_leds;
    w_tx_data_n  = r_tx_data;
    w_tx_start_n = 1'b0;
`ifdef CALC_ECHO_EN
    w_echo_n     = r_echo;
    w_rx_byte_n  = r_rx_byte;
`endif
    case (r_state)
      S_A, S_B: begin
        if (w_echo_go) begin
          w_tx_start_n = 1'b1;
          w_tx_data_n  = i_rx_data;
          w_ret_n      = r_state;
          w_state_n    = S_WAIT;
`ifdef CALC_ECHO_EN
          w_echo_n     = 1'b1;
          w_rx_byte_n  = i_rx_data;
`endif
        end else if (w_parse_v) begin
`ifdef CALC_ECHO_EN
          w_echo_n = 1'b0;
`endif
          if (w_is_digit) begin
            if (r_cnt == CW'(MAX_DIGITS)) begin
              w_state_n = S_ERR;
            end else begin
              w_cnt_n = r_cnt + CW'(1);
              if (r_state == S_A) w_a_n = f_acc(r_a, w_byte[3:0]);
              else                w_b_n = f_acc(r_b, w_byte[3:0]);
            end
          end else if (r_state == S_A && w_op_ok && r_cnt != '0) begin
            w_op_n    = w_opcode;
            w_cnt_n   = '0;
            w_state_n = S_B;
          end else if (r_state == S_B && w_byte == CR_CHAR && r_cnt != '0) begin
            w_state_n = S_EXEC;
          end else begin
            w_state_n = S_ERR;
          end
        end
      end
      S_EXEC: begin
        w_leds_n  = i_alu_res[7:0];
        w_res_n   = i_alu_res;
        w_state_n = S_TX_HI;
      end
      S_TX_HI: begin
        w_tx_start_n = 1'b1;
        w_tx_data_n  = f_hex(r_res[7:4]);
        w_ret_n      = S_TX_LO;
        w_state_n    = S_WAIT;
      end
      S_TX_LO: begin
        w_tx_start_n = 1'b1;
        w_tx_data_n  = f_hex(r_res[3:0]);
        w_ret_n      = S_TX_CR;
        w_state_n    = S_WAIT;
      end
      S_TX_CR: begin
        w_tx_start_n = 1'b1;
        w_tx_data_n  = CR_CHAR;
        w_ret_n      = S_A;
        w_state_n    = S_WAIT;
      end
      S_ERR: begin
        w_tx_start_n = 1'b1;
        w_tx_data_n  = 8'h3F;
        w_a_n        = '0;
        w_b_n        = '0;
        w_cnt_n      = '0;
        w_ret_n      = S_TX_CR;
        w_state_n    = S_WAIT;
      end
      S_WAIT: begin
        // returning from the final CR ends the command; returning from an echo does not
        if (i_tx_done) begin
          w_state_n = r_ret;
          if (r_ret == S_A && w_ret_clear) begin
            w_a_n   = '0;
            w_b_n   = '0;
            w_cnt_n = '0;
          end
        end
      end
      default: w_state_n = S_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_A;
      r_ret      <= S_A;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_op       <= 6'b100000;
      r_leds     <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
`ifdef CALC_ECHO_EN
      r_echo     <= 1'b0;
      r_rx_byte  <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_ret      <= w_ret_n;
      r_a        <= w_a_n;
      r_b        <= w_b_n;
      r_res      <= w_res_n;
      r_cnt      <= w_cnt_n;
      r_op       <= w_op_n;
      r_leds     <= w_leds_n;
      r_tx_data  <= w_tx_data_n;
      r_tx_start <= w_tx_start_n;
`ifdef CALC_ECHO_EN
      r_echo     <= w_echo_n;
      r_rx_byte  <= w_rx_byte_n;
`endif
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_alu_a    = r_a;
  assign o_alu_b    = r_b;
  assign o_alu_op   = r_op;
  assign o_leds     = r_leds;
  assign o_state    = 8'b1 << r_state;

endmodule
